// File: rtl/column_fb_pkg.sv
// Shared types and register map for the column frame buffer.
package column_fb_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    FRONT   = 2'd3
  } buf_state_t;

  localparam logic [3:0] ADDR_ABORT  = 4'd0;
  localparam logic [3:0] ADDR_DATA   = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_CLEAR  = 4'd2;
  localparam logic [3:0] ADDR_WCOL   = 4'd3;

  localparam int unsigned STAT_READY    = 0;
  localparam int unsigned STAT_OVERFLOW = 1;
  localparam int unsigned STAT_STALLED  = 2;
  localparam int unsigned STAT_DROP_LSB = 8;

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column store: one write port, one registered read port,
// both addressed by (buffer, column).
module column_ram #(
  parameter int unsigned NUM_BUFS = 3,
  parameter int unsigned NUM_COLS = 640,
  parameter int unsigned COL_W    = 80
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_BUFS)-1:0] wr_buf,
  input  logic [$clog2(NUM_COLS)-1:0] wr_col,
  input  logic [COL_W-1:0]            wr_data,
  input  logic [$clog2(NUM_BUFS)-1:0] rd_buf,
  input  logic [$clog2(NUM_COLS)-1:0] rd_col,
  output logic [COL_W-1:0]            rd_data
);

  localparam int unsigned DEPTH  = NUM_BUFS * NUM_COLS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [COL_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Linear address: buffer-major, column-minor.
  always_comb begin
    wr_addr = ADDR_W'(wr_buf) * ADDR_W'(NUM_COLS) + ADDR_W'(wr_col);
    rd_addr = ADDR_W'(rd_buf) * ADDR_W'(NUM_COLS) + ADDR_W'(rd_col);
  end

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/column_frame_buffer.sv
// N-way column frame buffer: assembles Avalon word writes into column
// records, tracks per-buffer state, promotes the newest frame at the
// frame boundary and exposes status.
module column_frame_buffer
  import column_fb_pkg::*;
#(
  parameter int unsigned NUM_COLS      = 640,
  parameter int unsigned NUM_BUFS      = 3,
  parameter int unsigned WORD_W        = 16,
  parameter int unsigned WORDS_PER_COL = 5,
  parameter int unsigned COL_W         = WORD_W * WORDS_PER_COL
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [3:0]                  address,
  input  logic [WORD_W-1:0]           writedata,
  output logic [WORD_W-1:0]           readdata,
  input  logic                        frame_boundary,
  input  logic [$clog2(NUM_COLS)-1:0] rd_col,
  output logic [COL_W-1:0]            rd_data,
  output logic [$clog2(NUM_BUFS)-1:0] front_idx
);

  localparam int unsigned COL_AW = $clog2(NUM_COLS);
  localparam int unsigned BUF_AW = $clog2(NUM_BUFS);
  localparam int unsigned CNT_W  = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;

  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_COL - 1);
  localparam logic [COL_AW-1:0] LAST_COL  = COL_AW'(NUM_COLS - 1);

  buf_state_t buf_state [NUM_BUFS];
  buf_state_t nxt_state [NUM_BUFS];

  logic              writing;
  logic              nxt_writing;
  logic [BUF_AW-1:0] wbuf;
  logic [BUF_AW-1:0] nxt_wbuf;
  logic [BUF_AW-1:0] eff_buf;
  logic [BUF_AW-1:0] nxt_front;
  logic [BUF_AW-1:0] free_idx;
  logic [BUF_AW-1:0] ready_idx;
  logic              free_found;
  logic              ready_found;

  logic [CNT_W-1:0]  wcnt;
  logic [COL_AW-1:0] wcol;
  logic [COL_W-1:0]  col_reg;
  logic [COL_W-1:0]  wr_rec;

  logic              overflow;
  logic              stalled;
  logic [7:0]        drop_cnt;
  logic [15:0]       status_word;

  logic wr_sel;
  logic data_wr;
  logic abort_wr;
  logic clear_wr;
  logic accept;
  logic discard;
  logic col_done;
  logic frame_done;
  logic drop;

  // Register write decode.
  always_comb begin
    wr_sel   = chipselect && write;
    data_wr  = wr_sel && (address == ADDR_DATA);
    abort_wr = wr_sel && (address == ADDR_ABORT);
    clear_wr = wr_sel && (address == ADDR_CLEAR);
  end

  // Lowest-index FREE buffer and the (at most one) READY buffer.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int unsigned i = 0; i < NUM_BUFS; i++) begin
      if (!free_found && buf_state[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = BUF_AW'(i);
      end
      if (!ready_found && buf_state[i] == READY) begin
        ready_found = 1'b1;
        ready_idx   = BUF_AW'(i);
      end
    end
  end

  // Buffer state transitions: acquisition, completion, mailbox drop, promotion.
  always_comb begin
    nxt_state   = buf_state;
    nxt_writing = writing;
    nxt_wbuf    = wbuf;
    nxt_front   = front_idx;
    eff_buf     = wbuf;
    accept      = 1'b0;
    discard     = 1'b0;
    drop        = 1'b0;

    if (data_wr) begin
      if (writing) begin
        accept = 1'b1;
      end else if (free_found) begin
        accept              = 1'b1;
        eff_buf             = free_idx;
        nxt_state[free_idx] = WRITING;
        nxt_writing         = 1'b1;
        nxt_wbuf            = free_idx;
      end else begin
        discard = 1'b1;
      end
    end

    col_done   = accept && (wcnt == LAST_WORD);
    frame_done = col_done && (wcol == LAST_COL);

    // A completing frame bypasses READY when the boundary lands on the same cycle.
    if (frame_done) begin
      nxt_writing = 1'b0;
      if (ready_found) begin
        nxt_state[ready_idx] = FREE;
        drop                 = 1'b1;
      end
      if (frame_boundary) begin
        nxt_state[front_idx] = FREE;
        nxt_state[eff_buf]   = FRONT;
        nxt_front            = eff_buf;
      end else begin
        nxt_state[eff_buf] = READY;
      end
    end else if (frame_boundary && ready_found) begin
      nxt_state[front_idx] = FREE;
      nxt_state[ready_idx] = FRONT;
      nxt_front            = ready_idx;
    end
  end

  // Full record: latched words with the final word taken straight from the bus.
  always_comb begin
    wr_rec = col_reg;
    wr_rec[(WORDS_PER_COL - 1) * WORD_W +: WORD_W] = writedata;
  end

  // Buffer state, writer ownership and front index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_BUFS; i++) begin
        buf_state[i] <= (i == 0) ? FRONT : FREE;
      end
      writing   <= 1'b0;
      wbuf      <= '0;
      front_idx <= '0;
    end else begin
      buf_state <= nxt_state;
      writing   <= nxt_writing;
      wbuf      <= nxt_wbuf;
      front_idx <= nxt_front;
    end
  end

  // Word and column counters plus the partial-record latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt    <= '0;
      wcol    <= '0;
      col_reg <= '0;
    end else if (abort_wr) begin
      wcnt <= '0;
      wcol <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < WORDS_PER_COL; k++) begin
        if (wcnt == CNT_W'(k)) begin
          col_reg[k * WORD_W +: WORD_W] <= writedata;
        end
      end
      if (col_done) begin
        wcnt <= '0;
        wcol <= frame_done ? '0 : wcol + COL_AW'(1);
      end else begin
        wcnt <= wcnt + CNT_W'(1);
      end
    end
  end

  // Overflow, stall and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      stalled  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (clear_wr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (discard) begin
          overflow <= 1'b1;
        end
        if (drop && drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
      if (discard) begin
        stalled <= 1'b1;
      end else if (accept) begin
        stalled <= 1'b0;
      end
    end
  end

  // Zero wait-state register read.
  always_comb begin
    status_word                         = '0;
    status_word[STAT_READY]             = ready_found;
    status_word[STAT_OVERFLOW]          = overflow;
    status_word[STAT_STALLED]           = stalled;
    status_word[STAT_DROP_LSB +: 8]     = drop_cnt;
    case (address)
      ADDR_STATUS: readdata = WORD_W'(status_word);
      ADDR_WCOL:   readdata = WORD_W'(wcol);
      default:     readdata = '0;
    endcase
  end

  column_ram #(
    .NUM_BUFS (NUM_BUFS),
    .NUM_COLS (NUM_COLS),
    .COL_W    (COL_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (col_done),
    .wr_buf  (eff_buf),
    .wr_col  (wcol),
    .wr_data (wr_rec),
    .rd_buf  (front_idx),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

endmodule
